// File: rtl/texture_upload_ctrl.sv
// rtl/texture_upload_ctrl.sv - streams texel pairs into texture memory; define TEX_UPLOAD_TLAST_CHECK_EN
// to end an upload early with a sticky error when tlast arrives before the configured count.
module texture_upload_ctrl #(
  parameter int ADDR_WIDTH       = 17,
  parameter int CMD_STREAM_WIDTH = 64
) (
  input  logic                        aclk,
  input  logic                        reset,
  input  logic                        conf_valid,
  input  logic [ADDR_WIDTH-1:0]       conf_base_addr,
  input  logic [ADDR_WIDTH:0]         conf_texel_count,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  input  logic [CMD_STREAM_WIDTH-1:0] s_axis_tdata,
  output logic                        tex_wr_en,
  output logic [ADDR_WIDTH-1:0]       tex_wr_addr,
  output logic [31:0]                 tex_wr_data,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

`ifdef TEX_UPLOAD_TLAST_CHECK_EN
  localparam bit TLAST_CHECK = 1'b1;
`else
  localparam bit TLAST_CHECK = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;

  typedef enum logic [2:0] {IDLE, RECV, WR_LO, WR_HI, DONE} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [ADDR_WIDTH:0]         remaining_q, remaining_d;
  logic [CMD_STREAM_WIDTH-1:0] beat_q, beat_d;
  logic                        last_q, last_d;
  logic                        err_q, err_d;
  logic                        tready_q, tready_d;
  logic                        wr_en_q, wr_en_d;
  logic [31:0]                 wr_data_q, wr_data_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [ADDR_WIDTH:0]         rem_dec;

  assign rem_dec = remaining_q - REM_ONE;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beat_d      = beat_q;
    last_d      = last_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (conf_valid) begin
          addr_d      = conf_base_addr;
          remaining_d = conf_texel_count;
          err_d       = 1'b0;
          state_d     = (conf_texel_count == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (s_axis_tvalid && tready_q) begin
          beat_d  = s_axis_tdata;
          last_d  = s_axis_tlast & TLAST_CHECK;
          state_d = WR_LO;
        end
      end
      WR_LO: begin
        addr_d      = addr_q + ADDR_ONE;
        remaining_d = rem_dec;
        state_d     = (rem_dec == '0) ? DONE : WR_HI;
      end
      WR_HI: begin
        addr_d      = addr_q + ADDR_ONE;
        remaining_d = rem_dec;
        if (rem_dec == '0) begin
          state_d = DONE;
        end else if (last_q) begin
          // tlast on a beat with texels still owed: stop here and flag it
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          state_d = RECV;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    tready_d  = (state_d == RECV);
    wr_en_d   = (state_d == WR_LO) || (state_d == WR_HI);
    wr_data_d = (state_d == WR_HI) ? beat_d[63:32] : beat_d[31:0];
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      beat_q      <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      tready_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
      err_q       <= err_d;
      tready_q    <= tready_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign tex_wr_en     = wr_en_q;
  assign tex_wr_addr   = addr_q;
  assign tex_wr_data   = wr_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = err_q;

endmodule

// File: tb/tb_texture_upload_ctrl.sv
// tb/tb_texture_upload_ctrl.sv - directed self-checking bench for texture_upload_ctrl
module tb_texture_upload_ctrl;
  localparam int AW = 17;

  logic          aclk = 1'b0;
  logic          reset = 1'b1;
  logic          conf_valid = 1'b0;
  logic [AW-1:0] conf_base_addr = '0;
  logic [AW:0]   conf_texel_count = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic [63:0]   s_axis_tdata = '0;
  logic          s_axis_tready;
  logic          tex_wr_en;
  logic [AW-1:0] tex_wr_addr;
  logic [31:0]   tex_wr_data;
  logic          busy, done, error;

  texture_upload_ctrl #(.ADDR_WIDTH(AW), .CMD_STREAM_WIDTH(64)) dut (
    .aclk(aclk), .reset(reset), .conf_valid(conf_valid),
    .conf_base_addr(conf_base_addr), .conf_texel_count(conf_texel_count),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
    .tex_wr_en(tex_wr_en), .tex_wr_addr(tex_wr_addr), .tex_wr_data(tex_wr_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge aclk) cyc++;

  // Monitor: logs writes and pulses on the falling edge
  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  int            wc[$];
  bit hs = 1'b0;
  int done_cnt = 0, done_cyc = 0, busy_cnt = 0, acc_cnt = 0, tready_cnt = 0;
  always @(negedge aclk) begin
    hs = s_axis_tvalid && s_axis_tready && !reset;
    if (hs) acc_cnt++;
    if (s_axis_tready) tready_cnt++;
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (tex_wr_en) begin
      wa.push_back(tex_wr_addr);
      wd.push_back(tex_wr_data);
      wc.push_back(cyc);
    end
  end

  // Stream source: beats queued by the stimulus, consumed on handshake
  logic [63:0] bq[$];
  bit          lq[$];
  int rd_ptr = 0;
  int skip = 0;
  always @(posedge aclk) begin
    #1;
    if (hs) rd_ptr++;
    if (rd_ptr + skip < bq.size()) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = bq[rd_ptr + skip];
      s_axis_tlast  = lq[rd_ptr + skip];
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
    end
  end

  int conf_cyc, wr_base, done_base, busy_base, acc_base, tready_base;

  task automatic tick();
    @(negedge aclk);
    #1;
  endtask

  task automatic add_beat(input logic [31:0] hi, input logic [31:0] lo, input bit last);
    bq.push_back({hi, lo});
    lq.push_back(last);
  endtask

  task automatic flush_beats();
    @(posedge aclk);
    #2;
    skip = bq.size() - rd_ptr;
  endtask

  task automatic start(input logic [AW-1:0] base, input logic [AW:0] count);
    @(posedge aclk);
    #2;
    wr_base = wa.size(); done_base = done_cnt; busy_base = busy_cnt;
    acc_base = acc_cnt; tready_base = tready_cnt;
    conf_base_addr = base;
    conf_texel_count = count;
    conf_valid = 1'b1;
    conf_cyc = cyc;
    @(posedge aclk);
    #2;
    conf_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != done_base) break;
    end
    check_eq("done_seen", done_cnt != done_base, 1);
    repeat (4) tick();
  endtask

  task automatic check_writes(input string tag, input logic [AW-1:0] ea[$], input logic [31:0] ed[$]);
    check_eq({tag, "_nwr"}, wa.size() - wr_base, ea.size());
    for (int i = 0; i < ea.size() && wr_base + i < wa.size(); i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), wa[wr_base + i], ea[i]);
      check_eq($sformatf("%s_data%0d", tag, i), wd[wr_base + i], ed[i]);
    end
  endtask

  initial begin
    repeat (3) tick();
    check_eq("rst_tready", s_axis_tready, 0);
    check_eq("rst_wr_en", tex_wr_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_error", error, 0);
    reset = 1'b0;
    repeat (2) tick();

    // count=4 back to back
    add_beat(32'hB0B0_B0B0, 32'hA0A0_A0A0, 1'b0);
    add_beat(32'hD0D0_D0D0, 32'hC0C0_C0C0, 1'b0);
    start(17'h10, 4);
    wait_done(40);
    check_writes("c4", '{17'h10, 17'h11, 17'h12, 17'h13},
                 '{32'hA0A0_A0A0, 32'hB0B0_B0B0, 32'hC0C0_C0C0, 32'hD0D0_D0D0});
    if (wa.size() - wr_base == 4) begin
      check_eq("c4_lat_lo", wc[wr_base] - conf_cyc, 2);
      check_eq("c4_lat_hi", wc[wr_base + 1] - wc[wr_base], 1);
      check_eq("c4_beat_gap", wc[wr_base + 2] - wc[wr_base], 3);
      check_eq("c4_hi2", wc[wr_base + 3] - wc[wr_base + 2], 1);
    end
    check_eq("c4_done_cnt", done_cnt - done_base, 1);
    check_eq("c4_done_lat", done_cyc - conf_cyc, 7);
    check_eq("c4_busy_cyc", busy_cnt - busy_base, 7);
    check_eq("c4_busy_end", busy, 0);

    // count=3: upper texel of beat 2 dropped, beat 3 left in the stream
    add_beat(32'h0000_B002, 32'h0000_A002, 1'b0);
    add_beat(32'h0000_D002, 32'h0000_C002, 1'b0);
    add_beat(32'h0000_F002, 32'h0000_E002, 1'b0);
    start(17'h20, 3);
    wait_done(40);
    check_writes("c3", '{17'h20, 17'h21, 17'h22}, '{32'h0000_A002, 32'h0000_B002, 32'h0000_C002});
    check_eq("c3_acc", acc_cnt - acc_base, 2);
    check_eq("c3_left", bq.size() - rd_ptr - skip, 1);
    check_eq("c3_done_lat", done_cyc - conf_cyc, 6);
    check_eq("c3_tready_end", s_axis_tready, 0);
    flush_beats();

    // address wrap
    add_beat(32'h2222_2222, 32'h1111_1111, 1'b0);
    start(17'h1FFFF, 2);
    wait_done(40);
    check_writes("wrap", '{17'h1FFFF, 17'h00000}, '{32'h1111_1111, 32'h2222_2222});
    check_eq("wrap_done_lat", done_cyc - conf_cyc, 4);

    // count=0
    start(17'h55, 0);
    wait_done(20);
    check_eq("c0_nwr", wa.size() - wr_base, 0);
    check_eq("c0_tready", tready_cnt - tready_base, 0);
    check_eq("c0_done_lat", done_cyc - conf_cyc, 1);
    check_eq("c0_busy_cyc", busy_cnt - busy_base, 1);

    // conf_valid during an upload is ignored
    add_beat(32'h0000_0402, 32'h0000_0401, 1'b0);
    add_beat(32'h0000_0404, 32'h0000_0403, 1'b0);
    start(17'h40, 4);
    @(posedge aclk); #2;
    conf_base_addr = 17'h80; conf_texel_count = 2; conf_valid = 1'b1;
    @(posedge aclk); #2;
    conf_valid = 1'b0;
    wait_done(40);
    check_writes("ign", '{17'h40, 17'h41, 17'h42, 17'h43},
                 '{32'h0401, 32'h0402, 32'h0403, 32'h0404});
    check_eq("ign_done_cnt", done_cnt - done_base, 1);
    check_eq("ign_busy_end", busy, 0);

    // reset after the first write of a count=8 upload; reset beats a same-cycle conf
    for (int i = 0; i < 4; i++) add_beat(32'h5000 + 2 * i + 1, 32'h5000 + 2 * i, 1'b0);
    start(17'h100, 8);
    for (int i = 0; i < 20 && wa.size() == wr_base; i++) tick();
    check_eq("rst_first_wr", wa.size() - wr_base, 1);
    reset = 1'b1;
    conf_valid = 1'b1; conf_base_addr = 17'h1F0; conf_texel_count = 1;
    tick();
    reset = 1'b0;
    conf_valid = 1'b0;
    check_eq("mid_rst_outs", {s_axis_tready, tex_wr_en, busy, done, error}, 5'b0);
    check_eq("mid_rst_addr", tex_wr_addr, 0);
    repeat (12) tick();
    check_eq("mid_rst_nwr", wa.size() - wr_base, 1);
    check_eq("mid_rst_done", done_cnt - done_base, 0);
    check_eq("mid_rst_busy", busy, 0);
    flush_beats();
    add_beat(32'h0000_2222, 32'h0000_1111, 1'b0);
    start(17'h200, 2);
    wait_done(40);
    check_writes("post_rst", '{17'h200, 17'h201}, '{32'h0000_1111, 32'h0000_2222});

    // tlast on beat 2 of a count=8 upload
    for (int i = 0; i < 4; i++) add_beat(32'h7000 + 2 * i + 1, 32'h7000 + 2 * i, i == 1);
    start(17'h300, 8);
    wait_done(60);
`ifdef TEX_UPLOAD_TLAST_CHECK_EN
    check_eq("tlast_nwr", wa.size() - wr_base, 4);
    check_eq("tlast_error", error, 1);
`else
    check_eq("tlast_nwr", wa.size() - wr_base, 8);
    check_eq("tlast_error", error, 0);
`endif
    check_eq("tlast_done_cnt", done_cnt - done_base, 1);
    flush_beats();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
